// File: rtl/rob.sv
// Reorder buffer: in-order retirement of out-of-order results, with branch/JALR
// target resolution at commit and a one-cycle flush pulse on misprediction.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef ROB_LR_WIDTH
`define ROB_LR_WIDTH $clog2(MaxROB)
`endif

module rob #(
  parameter int unsigned MaxROB = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  output logic                        ROB_full,
  output logic [`ROB_LR_WIDTH-1:0]    b1,
  input  logic                        insqueue_to_ROB_needchange,
  input  logic [`INST_TYPE_WIDTH-1:0] ROB_s_ordertype_b1_,
  input  logic [4:0]                  ROB_s_dest_b1_,
  input  logic [`DATA_WIDTH-1:0]      ROB_s_pc_b1_,
  input  logic [`DATA_WIDTH-1:0]      ROB_s_jumppc_b1_,
  input  logic [`DATA_WIDTH-1:0]      ROB_s_prednextpc_b1_,
  input  logic                        RS_to_ROB_needchange,
  input  logic                        RS_to_ROB_needchange2,
  input  logic [`ROB_LR_WIDTH-1:0]    b2,
  input  logic [`DATA_WIDTH-1:0]      ROB_s_value_b2_,
  input  logic [`DATA_WIDTH-1:0]      ROB_s_jumppc_b2_,
  input  logic                        ROB_s_ready_b2_,
  input  logic                        SLB_to_ROB_needchange,
  input  logic [`ROB_LR_WIDTH-1:0]    b4,
  input  logic [`DATA_WIDTH-1:0]      SLB_to_ROB_loadvalue,
  output logic                        ROB_to_RS_needchange,
  output logic [`ROB_LR_WIDTH-1:0]    b3,
  output logic [`DATA_WIDTH-1:0]      ROB_to_RS_value_b3,
  output logic                        ROB_to_Reg_we,
  output logic [4:0]                  ROB_to_Reg_rd,
  output logic                        ROB_to_SLB_storecommit,
  output logic                        Clear_flag,
  output logic [`DATA_WIDTH-1:0]      Clear_pc,
  input  logic [`ROB_LR_WIDTH-1:0]    qa,
  input  logic [`ROB_LR_WIDTH-1:0]    qb,
  output logic                        qa_ready,
  output logic [`DATA_WIDTH-1:0]      qa_value,
  output logic                        qb_ready,
  output logic [`DATA_WIDTH-1:0]      qb_value
);

  localparam int unsigned Lw = $clog2(MaxROB);
  localparam int unsigned Dw = `DATA_WIDTH;
  localparam logic [Lw:0] FullCount = (Lw + 1)'(MaxROB);

  typedef logic [`INST_TYPE_WIDTH-1:0] ty_t;

  // Instruction class codes shared with the decoder.
  localparam ty_t TyLui  = ty_t'(1);
  localparam ty_t TyJal  = ty_t'(3);
  localparam ty_t TyJalr = ty_t'(4);
  localparam ty_t TyBeq  = ty_t'(5);
  localparam ty_t TyBgeu = ty_t'(10);
  localparam ty_t TySb   = ty_t'(16);
  localparam ty_t TySw   = ty_t'(18);

  logic [MaxROB-1:0] busy_q, ready_q;
  ty_t               ordertype_q  [MaxROB];
  logic [4:0]        dest_q       [MaxROB];
  logic [Dw-1:0]     pc_q         [MaxROB];
  logic [Dw-1:0]     jumppc_q     [MaxROB];
  logic [Dw-1:0]     prednextpc_q [MaxROB];
  logic [Dw-1:0]     value_q      [MaxROB];
  logic [Lw-1:0]     head_q, tail_q;
  logic [Lw:0]       count_q;
  logic              clear_q;
  logic [Dw-1:0]     clear_pc_q;

  logic          active, full, commit, mispredict, do_alloc, rs_wb, slb_wb;
  logic          head_branch, head_store, head_jalr, alloc_ready;
  ty_t           head_ty;
  logic [Dw-1:0] head_pc4, actual_pc, alloc_value;

  always_comb begin
    active      = rdy && !clear_q;
    full        = (count_q == FullCount);
    head_ty     = ordertype_q[head_q];
    head_pc4    = pc_q[head_q] + Dw'(4);
    head_branch = (head_ty >= TyBeq) && (head_ty <= TyBgeu);
    head_store  = (head_ty >= TySb) && (head_ty <= TySw);
    head_jalr   = (head_ty == TyJalr);
    commit      = active && busy_q[head_q] && ready_q[head_q];
    if (head_branch) begin
      actual_pc = value_q[head_q][0] ? jumppc_q[head_q] : head_pc4;
    end else if (head_jalr) begin
      actual_pc = jumppc_q[head_q];
    end else begin
      actual_pc = head_pc4;
    end
    mispredict  = commit && (actual_pc != prednextpc_q[head_q]);
    do_alloc    = active && insqueue_to_ROB_needchange && !full;
    rs_wb       = active && (RS_to_ROB_needchange || RS_to_ROB_needchange2) && busy_q[b2];
    slb_wb      = active && SLB_to_ROB_needchange && busy_q[b4];
    alloc_ready = (ROB_s_ordertype_b1_ == TyJal) || (ROB_s_ordertype_b1_ == TyLui);
    // LUI carries its upper immediate in the jumppc field.
    alloc_value = (ROB_s_ordertype_b1_ == TyJal) ? ROB_s_pc_b1_ + Dw'(4) : ROB_s_jumppc_b1_;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      clear_q    <= 1'b0;
      clear_pc_q <= '0;
    end else begin
      clear_q <= 1'b0;
      if (rs_wb) begin
        value_q[b2] <= ROB_s_value_b2_;
        ready_q[b2] <= ROB_s_ready_b2_;
        if (RS_to_ROB_needchange2) jumppc_q[b2] <= ROB_s_jumppc_b2_;
      end
      if (slb_wb) begin
        value_q[b4] <= SLB_to_ROB_loadvalue;
        ready_q[b4] <= 1'b1;
      end
      if (do_alloc) begin
        busy_q[tail_q]       <= 1'b1;
        ready_q[tail_q]      <= alloc_ready;
        ordertype_q[tail_q]  <= ROB_s_ordertype_b1_;
        dest_q[tail_q]       <= ROB_s_dest_b1_;
        pc_q[tail_q]         <= ROB_s_pc_b1_;
        jumppc_q[tail_q]     <= ROB_s_jumppc_b1_;
        prednextpc_q[tail_q] <= ROB_s_prednextpc_b1_;
        value_q[tail_q]      <= alloc_value;
        tail_q               <= tail_q + 1'b1;
      end
      if (commit) begin
        busy_q[head_q] <= 1'b0;
        head_q         <= head_q + 1'b1;
      end
      count_q <= count_q + (Lw + 1)'(do_alloc) - (Lw + 1)'(commit);
      // A wrong-path commit squashes everything younger, including this cycle's alloc.
      if (mispredict) begin
        busy_q     <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        clear_q    <= 1'b1;
        clear_pc_q <= actual_pc;
      end
    end
  end

  always_comb begin
    ROB_full               = full;
    b1                     = tail_q;
    ROB_to_RS_needchange   = commit;
    b3                     = commit ? head_q : '0;
    ROB_to_RS_value_b3     = commit ? value_q[head_q] : '0;
    ROB_to_Reg_we          = commit && !head_branch && !head_store && (dest_q[head_q] != 5'd0);
    ROB_to_Reg_rd          = ROB_to_Reg_we ? dest_q[head_q] : 5'd0;
    ROB_to_SLB_storecommit = commit && head_store;
    Clear_flag             = clear_q;
    Clear_pc               = clear_pc_q;
    qa_ready               = busy_q[qa] && ready_q[qa];
    qa_value               = value_q[qa];
    qb_ready               = busy_q[qb] && ready_q[qb];
    qb_value               = value_q[qb];
  end

endmodule
